seg7_serial_scanner: RTL

- Display scanner that sits directly downstream of the clock-to-7-segment converter.
- Drives the converter's 4-bit digit select through 0..5 and samples the returned 8-bit segment pattern (bit 7 = decimal point).
- Serialises a 16-bit word {digit-enable byte, segment byte} MSB-first into an external 74HC595-style shift-register chain, then pulses the storage latch.
- Result: a time-multiplexed 6-digit display driven from 3 pins.

---
 rtl/seg7_serial_scanner_if.sv | 36 +++
 rtl/seg7_serial_scanner.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg7_serial_scanner_if.sv
// Scanner bundle: converter handshake (select out, segment pattern back)
// plus the three-wire shift-register chain and status flags.
interface seg7_serial_scanner_if;
  logic       i_en;
  logic [7:0] i_7seg;
  logic [3:0] o_seg_select;
  logic       o_serial_data;
  logic       o_serial_clk;
  logic       o_serial_latch;
  logic       o_busy;
  logic       o_frame_done;

  // Environment side: enables the scan, returns segment patterns, watches pins
  modport master (
    output i_en,
    output i_7seg,
    input  o_seg_select,
    input  o_serial_data,
    input  o_serial_clk,
    input  o_serial_latch,
    input  o_busy,
    input  o_frame_done
  );

  // Scanner side
  modport slave (
    input  i_en,
    input  i_7seg,
    output o_seg_select,
    output o_serial_data,
    output o_serial_clk,
    output o_serial_latch,
    output o_busy,
    output o_frame_done
  );
endinterface

// File: rtl/seg7_serial_scanner.sv
// Six-digit display scanner: walks the converter's digit select 0..5, samples
// the returned segment byte, and clocks {digit enables, segments} MSB-first
// into a 74HC595-style chain followed by a storage latch pulse.
module seg7_serial_scanner #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [7:0]  SEG_INVERT = 8'h00,
  parameter logic [7:0]  DIG_INVERT = 8'h00
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  seg7_serial_scanner_if.slave scan_if
);

  localparam int              DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  localparam logic [3:0] SEL_LAST = 4'd5;
  localparam logic [4:0] BIT_LAST = 5'd15;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [4:0]       bit_q,   bit_d;
  logic [15:0]      sreg_q,  sreg_d;
  logic [3:0]       sel_q,   sel_d;
  logic             sclk_q,  sclk_d;
  logic             sdat_q,  sdat_d;
  logic             latch_q, latch_d;
  logic             fdone_q, fdone_d;
  logic [7:0]       digit_byte;
  logic             div_wrap;

  // One-hot digit enable for the current select; select never exceeds 5,
  // so bits 7:6 stay clear.
  always_comb begin
    digit_byte = 8'd1 << sel_q;
  end

  // Next-state logic; pin values are computed from the next state so the
  // pins themselves come straight out of flops.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    sel_d    = sel_q;
    sclk_d   = 1'b0;
    div_wrap = (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: begin
        if (scan_if.i_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Only place the converter output is sampled
        sreg_d  = {digit_byte ^ DIG_INVERT, scan_if.i_7seg ^ SEG_INVERT};
        bit_d   = '0;
        div_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sclk_d = sclk_q;
        if (div_wrap) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of the high phase: drop the clock and present the next bit
            sclk_d = 1'b0;
            sreg_d = {sreg_q[14:0], 1'b0};
            bit_d  = bit_q + 5'd1;
            if (bit_q == BIT_LAST) state_d = ST_LATCH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (div_wrap) begin
          div_d   = '0;
          state_d = ST_NEXT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_NEXT: begin
        sel_d   = (sel_q == SEL_LAST) ? 4'd0 : sel_q + 4'd1;
        state_d = scan_if.i_en ? ST_LOAD : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sdat_d  = (state_d == ST_SHIFT) ? sreg_d[15] : 1'b0;
    latch_d = (state_d == ST_LATCH);
    fdone_d = (state_d == ST_NEXT) && (sel_q == SEL_LAST);
  end

  // State and output registers, all cleared asynchronously
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      sel_q   <= '0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      latch_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      sel_q   <= sel_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      latch_q <= latch_d;
      fdone_q <= fdone_d;
    end
  end

  assign scan_if.o_seg_select   = sel_q;
  assign scan_if.o_serial_data  = sdat_q;
  assign scan_if.o_serial_clk   = sclk_q;
  assign scan_if.o_serial_latch = latch_q;
  assign scan_if.o_busy         = (state_q != ST_IDLE);
  assign scan_if.o_frame_done   = fdone_q;

endmodule
